// File: rtl/vi_sync_bus_rx.sv
// Destination side of a toggle-handshake CDC bus: synchronises the request
// toggle, captures the source word and returns an acknowledge toggle.
module vi_sync_bus_rx #(
    parameter int SIZE        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_dst,
    input  logic            rst_n_dst,
    input  logic            src_req_tgl,
    input  logic [SIZE-1:0] src_data,
    output logic            dst_ack_tgl,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     xfer_cnt,
    output logic            proto_err
);

    typedef enum logic {
        IDLE,
        VALID
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_seen_q, req_seen_d;
    logic [SIZE-1:0]        data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ack_q, ack_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   perr_q, perr_d;
    logic                   req_s;
    logic                   new_req;

    // Only the synchroniser chain ever samples the asynchronous toggle.
    always_ff @(posedge clk_dst or negedge rst_n_dst) begin
        if (!rst_n_dst) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], src_req_tgl};
        end
    end

    assign req_s   = req_sync_q[SYNC_STAGES-1];
    assign new_req = (req_s != req_seen_q);

    always_ff @(posedge clk_dst or negedge rst_n_dst) begin
        if (!rst_n_dst) begin
            state_q    <= IDLE;
            req_seen_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            cnt_q      <= 16'h0000;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_seen_q <= req_seen_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            cnt_q      <= cnt_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_seen_d = req_seen_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ack_d      = ack_q;
        cnt_d      = cnt_q;
        perr_d     = perr_q;
        unique case (state_q)
            IDLE: begin
                if (new_req) begin
                    data_d     = src_data;
                    valid_d    = 1'b1;
                    req_seen_d = req_s;
                    state_d    = VALID;
                end
            end
            VALID: begin
                // A further toggle before our ack is a source-side violation.
                if (new_req) begin
                    perr_d = 1'b1;
                end
                if (out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dst_ack_tgl = ack_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign xfer_cnt    = cnt_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_vi_sync_bus_rx.sv
// Randomised self-checking bench for vi_sync_bus_rx with a queue-based
// reference model of the toggle handshake.
module tb_vi_sync_bus_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, rdy = 1'b0;
    logic [31:0] data = '0;
    logic        ack, ov, perr;
    logic [31:0] od;
    logic [15:0] cnt;
    logic        req3 = 1'b0, rdy3 = 1'b0;
    logic [31:0] data3 = '0;
    logic        ack3, ov3, perr3;
    logic [31:0] od3;
    logic [15:0] cnt3;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_cnt = '0;
    logic        m_ack = 1'b0;

    always #5 clk = ~clk;

    vi_sync_bus_rx #(.SIZE(32), .SYNC_STAGES(2)) dut (
        .clk_dst(clk), .rst_n_dst(rst_n), .src_req_tgl(req),
        .src_data(data), .dst_ack_tgl(ack), .out_data(od),
        .out_valid(ov), .out_ready(rdy), .xfer_cnt(cnt),
        .proto_err(perr)
    );

    vi_sync_bus_rx #(.SIZE(32), .SYNC_STAGES(3)) dut3 (
        .clk_dst(clk), .rst_n_dst(rst_n), .src_req_tgl(req3),
        .src_data(data3), .dst_ack_tgl(ack3), .out_data(od3),
        .out_valid(ov3), .out_ready(rdy3), .xfer_cnt(cnt3),
        .proto_err(perr3)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({ov, ack, cnt, perr, od} !== '0) begin
            errors++;
            $display("FAIL reset_async dut got v=%b a=%b c=%h e=%b d=%h want 0",
                     ov, ack, cnt, perr, od);
        end
        checks++;
        if ({ov3, ack3, cnt3, perr3, od3} !== '0) begin
            errors++;
            $display("FAIL reset_async dut3 got v=%b a=%b c=%h e=%b d=%h want 0",
                     ov3, ack3, cnt3, perr3, od3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = '0;
        m_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ov, ack, cnt, perr} !== '0) begin
            errors++;
            $display("FAIL reset_idle got v=%b a=%b c=%h e=%b want 0",
                     ov, ack, cnt, perr);
        end
    endtask

    task automatic test_single();
        rdy  = 1'b1;
        data = 32'hDEADBEEF;
        req  = ~req;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            checks++;
            if (ov !== (e == 3)) begin
                errors++;
                $display("FAIL single_latency edge %0d got v=%b want %b",
                         e, ov, (e == 3));
            end
        end
        checks++;
        if (od !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_data got %h want deadbeef", od);
        end
        @(negedge clk);
        m_ack = ~m_ack;
        m_cnt = m_cnt + 16'd1;
        checks++;
        if (ack !== m_ack || ov !== 1'b0 || cnt !== m_cnt) begin
            errors++;
            $display("FAIL single_ack got a=%b v=%b c=%h want a=%b v=0 c=%h",
                     ack, ov, cnt, m_ack, m_cnt);
        end
        rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        w    = $urandom;
        rdy  = 1'b0;
        data = w;
        req  = ~req;
        repeat (3) @(negedge clk);
        data = $urandom;
        checks++;
        if (ov !== 1'b1 || od !== w) begin
            errors++;
            $display("FAIL bp_capture got v=%b d=%h want v=1 d=%h", ov, od, w);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (ov !== 1'b1 || od !== w || ack !== m_ack || cnt !== m_cnt) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v=%b d=%h a=%b c=%h want 1 %h %b %h",
                         i, ov, od, ack, cnt, w, m_ack, m_cnt);
            end
        end
        rdy = 1'b1;
        @(negedge clk);
        m_ack = ~m_ack;
        m_cnt = m_cnt + 16'd1;
        checks++;
        if (ov !== 1'b0 || ack !== m_ack || cnt !== m_cnt) begin
            errors++;
            $display("FAIL bp_release got v=%b a=%b c=%h want 0 %b %h",
                     ov, ack, cnt, m_ack, m_cnt);
        end
        rdy = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] q[$];
        logic        last_ack;
        logic [31:0] w;
        int          sent;
        int          got;
        int          cyc;
        sent     = 0;
        got      = 0;
        cyc      = 0;
        last_ack = ack;
        w        = $urandom;
        q.push_back(w);
        data = w;
        req  = ~req;
        sent = 1;
        while (got < 300 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (ack !== last_ack) begin
                last_ack = ack;
                if (sent < 300) begin
                    w = $urandom;
                    q.push_back(w);
                    data = w;
                    req  = ~req;
                    sent++;
                end
            end
            rdy = 1'($urandom_range(0, 1));
            if (ov === 1'b1 && rdy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got d=%h want no word", od);
                end else begin
                    w = q.pop_front();
                    if (od !== w) begin
                        errors++;
                        $display("FAIL stream_word %0d got %h want %h", got, od, w);
                    end
                end
                got++;
                m_cnt = m_cnt + 16'd1;
                m_ack = ~m_ack;
            end
        end
        @(negedge clk);
        rdy = 1'b0;
        checks++;
        if (got != 300) begin
            errors++;
            $display("FAIL stream_timeout got %0d words want 300", got);
        end
        checks++;
        if (cnt !== m_cnt || ack !== m_ack || perr !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL stream_end got c=%h a=%b e=%b v=%b want %h %b 0 0",
                     cnt, ack, perr, ov, m_cnt, m_ack);
        end
    endtask

    task automatic test_wrap();
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 16'hFFFF;
        checks++;
        if (cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload got %h want ffff", cnt);
        end
        rdy  = 1'b1;
        data = $urandom;
        req  = ~req;
        repeat (4) @(negedge clk);
        m_cnt = m_cnt + 16'd1;
        m_ack = ~m_ack;
        checks++;
        if (cnt !== m_cnt || cnt !== 16'h0000 || ack !== m_ack) begin
            errors++;
            $display("FAIL wrap got c=%h a=%b want 0000 %b", cnt, ack, m_ack);
        end
        rdy = 1'b0;
    endtask

    task automatic test_violation();
        logic [31:0] a;
        logic [31:0] b;
        a    = $urandom;
        b    = ~a;
        rdy  = 1'b0;
        data = a;
        req  = ~req;
        repeat (3) @(negedge clk);
        checks++;
        if (ov !== 1'b1 || perr !== 1'b0) begin
            errors++;
            $display("FAIL viol_first got v=%b e=%b want 1 0", ov, perr);
        end
        data = b;
        req  = ~req;
        repeat (4) @(negedge clk);
        checks++;
        if (perr !== 1'b1 || ov !== 1'b1 || od !== a) begin
            errors++;
            $display("FAIL viol_flag got e=%b v=%b d=%h want 1 1 %h",
                     perr, ov, od, a);
        end
        rdy = 1'b1;
        @(negedge clk);
        m_cnt = m_cnt + 16'd1;
        m_ack = ~m_ack;
        checks++;
        if (ov !== 1'b0 || ack !== m_ack || cnt !== m_cnt) begin
            errors++;
            $display("FAIL viol_accept got v=%b a=%b c=%h want 0 %b %h",
                     ov, ack, cnt, m_ack, m_cnt);
        end
        @(negedge clk);
        checks++;
        if (ov !== 1'b1 || od !== b) begin
            errors++;
            $display("FAIL viol_redetect got v=%b d=%h want 1 %h", ov, od, b);
        end
        @(negedge clk);
        m_cnt = m_cnt + 16'd1;
        m_ack = ~m_ack;
        rdy   = 1'b0;
        checks++;
        if (perr !== 1'b1 || ack !== m_ack || cnt !== m_cnt) begin
            errors++;
            $display("FAIL viol_sticky got e=%b a=%b c=%h want 1 %b %h",
                     perr, ack, cnt, m_ack, m_cnt);
        end
    endtask

    task automatic test_reset_mid();
        rdy  = 1'b0;
        data = $urandom;
        req  = ~req;
        repeat (3) @(negedge clk);
        checks++;
        if (ov !== 1'b1) begin
            errors++;
            $display("FAIL rmid_valid got v=%b want 1", ov);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov, ack, cnt, perr, od} !== '0) begin
            errors++;
            $display("FAIL rmid_async got v=%b a=%b c=%h e=%b d=%h want 0",
                     ov, ack, cnt, perr, od);
        end
        req  = 1'b1;
        data = 32'h0BADF00D;
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = '0;
        m_ack = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            checks++;
            if (ov !== (e == 3)) begin
                errors++;
                $display("FAIL rmid_relatch edge %0d got v=%b want %b",
                         e, ov, (e == 3));
            end
        end
        rdy = 1'b1;
        @(negedge clk);
        m_cnt = m_cnt + 16'd1;
        m_ack = ~m_ack;
        rdy   = 1'b0;
        checks++;
        if (ack !== m_ack || cnt !== m_cnt) begin
            errors++;
            $display("FAIL rmid_ack got a=%b c=%h want %b %h",
                     ack, cnt, m_ack, m_cnt);
        end
    endtask

    task automatic test_sync3();
        rdy3  = 1'b1;
        data3 = 32'hDEADBEEF;
        req3  = ~req3;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            checks++;
            if (ov3 !== (e == 4)) begin
                errors++;
                $display("FAIL s3_latency edge %0d got v=%b want %b",
                         e, ov3, (e == 4));
            end
        end
        checks++;
        if (od3 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL s3_data got %h want deadbeef", od3);
        end
        @(negedge clk);
        checks++;
        if (ack3 !== 1'b1 || cnt3 !== 16'd1 || ov3 !== 1'b0 || perr3 !== 1'b0) begin
            errors++;
            $display("FAIL s3_ack got a=%b c=%h v=%b e=%b want 1 0001 0 0",
                     ack3, cnt3, ov3, perr3);
        end
        rdy3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_wrap();
        test_violation();
        test_reset_mid();
        test_sync3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
